// File: rtl/pdm_rss_sequencer.sv
// pdm_rss_sequencer
// Control and timing sequencer for a stereo pair of RSS PDM demodulator
// filters that share one PDM data line. The block generates the microphone
// clock, splits the line into left/right bit streams with write strobes,
// resets the filters on start, tracks decimation phase, discards warm-up
// outputs and hands each left/right pair out on a valid/ready interface
// with a sticky overrun flag.
module pdm_rss_sequencer #(
    parameter int N       = 16,
    parameter int CLK_DIV = 4,
    parameter int R       = 10,
    parameter int SETTLE  = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         pdm_data,
    output logic         pdm_clk,
    output logic         filt_rst,
    output logic         we_l,
    output logic         we_r,
    output logic         bit_l,
    output logic         bit_r,
    input  logic [N-1:0] filt_out_l,
    input  logic [N-1:0] filt_out_r,
    output logic [N-1:0] sample_l,
    output logic [N-1:0] sample_r,
    output logic         sample_valid,
    input  logic         sample_ready,
    output logic         overrun,
    input  logic         clr_overrun,
    output logic [1:0]   state
);

    localparam int HALF = CLK_DIV / 2;
    localparam int DW   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int PW   = $clog2(R + 1);
    localparam int SW   = $clog2(SETTLE + 2);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_FRST   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // Registered state
    logic [1:0]    state_q, state_d;
    logic          frst_cnt_q, frst_cnt_d;
    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [PW-1:0] ph_q, ph_d;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d;
    logic          pdm_clk_q, pdm_clk_d;
    logic          filt_rst_q, filt_rst_d;
    logic          we_l_q, we_l_d;
    logic          we_r_q, we_r_d;
    logic          bit_l_q, bit_l_d;
    logic          bit_r_q, bit_r_d;
    logic [N-1:0]  sample_l_q, sample_l_d;
    logic [N-1:0]  sample_r_q, sample_r_d;
    logic          valid_q, valid_d;
    logic          overrun_q, overrun_d;

    // Decoded conditions of the current cycle
    logic active_s;
    logic active_d_s;
    logic div_last_s;
    logic div_lsamp_s;
    logic capture_s;
    logic load_s;

    // Next-state logic: FSM, divider, channel split, decimation, handshake
    always_comb begin
        active_s    = (state_q == ST_SETTLE) || (state_q == ST_RUN);
        div_last_s  = (div_cnt_q == DW'(CLK_DIV - 1));
        div_lsamp_s = (div_cnt_q == DW'(HALF - 1));
        // The we_r that closes a capture period happens at div_cnt==0, so the
        // right filter output is settled one cycle later, at div_cnt==1.
        capture_s   = active_s && (div_cnt_q == DW'(1)) && (ph_q == PW'(R));
        load_s      = capture_s && (state_q == ST_RUN);

        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FRST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FRST: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (frst_cnt_q) begin
                    state_d = (SETTLE == 0) ? ST_RUN : ST_SETTLE;
                end else begin
                    state_d = ST_FRST;
                end
            end
            ST_SETTLE: begin
                if (!en && div_last_s) begin
                    state_d = ST_IDLE;
                end else if (capture_s && (settle_cnt_q == SW'(SETTLE - 1))) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (!en && div_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        active_d_s = (state_d == ST_SETTLE) || (state_d == ST_RUN);

        // Second FRST cycle is flagged so FRST lasts exactly two cycles
        frst_cnt_d = (state_q == ST_FRST) && (state_d == ST_FRST);

        if (active_s && active_d_s) begin
            if (div_last_s) begin
                div_cnt_d = {DW{1'b0}};
            end else begin
                div_cnt_d = div_cnt_q + DW'(1);
            end
        end else begin
            div_cnt_d = {DW{1'b0}};
        end

        pdm_clk_d  = active_d_s && (div_cnt_d < DW'(HALF));
        filt_rst_d = !active_d_s;

        // Left bit is sampled late in the high phase, right bit late in the
        // low phase; the right strobe still issues if the stop lands on it.
        we_l_d = active_s && active_d_s && div_lsamp_s;
        we_r_d = active_s && div_last_s;

        if (we_l_d) begin
            bit_l_d = pdm_data;
        end else begin
            bit_l_d = bit_l_q;
        end

        if (we_r_d) begin
            bit_r_d = pdm_data;
        end else begin
            bit_r_d = bit_r_q;
        end

        if (state_q == ST_FRST) begin
            ph_d = {PW{1'b0}};
        end else if (we_l_d) begin
            if (ph_q == PW'(R)) begin
                ph_d = PW'(1);
            end else begin
                ph_d = ph_q + PW'(1);
            end
        end else begin
            ph_d = ph_q;
        end

        if (state_q == ST_FRST) begin
            settle_cnt_d = {SW{1'b0}};
        end else if ((state_q == ST_SETTLE) && capture_s) begin
            settle_cnt_d = settle_cnt_q + SW'(1);
        end else begin
            settle_cnt_d = settle_cnt_q;
        end

        if (load_s) begin
            sample_l_d = filt_out_l;
            sample_r_d = filt_out_r;
            valid_d    = 1'b1;
        end else if (valid_q && sample_ready) begin
            sample_l_d = sample_l_q;
            sample_r_d = sample_r_q;
            valid_d    = 1'b0;
        end else begin
            sample_l_d = sample_l_q;
            sample_r_d = sample_r_q;
            valid_d    = valid_q;
        end

        // A new overrun takes priority over a simultaneous clear
        if (load_s && valid_q && !sample_ready) begin
            overrun_d = 1'b1;
        end else if (clr_overrun) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            frst_cnt_q   <= 1'b0;
            div_cnt_q    <= {DW{1'b0}};
            ph_q         <= {PW{1'b0}};
            settle_cnt_q <= {SW{1'b0}};
            pdm_clk_q    <= 1'b0;
            filt_rst_q   <= 1'b1;
            we_l_q       <= 1'b0;
            we_r_q       <= 1'b0;
            bit_l_q      <= 1'b0;
            bit_r_q      <= 1'b0;
            sample_l_q   <= {N{1'b0}};
            sample_r_q   <= {N{1'b0}};
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            frst_cnt_q   <= frst_cnt_d;
            div_cnt_q    <= div_cnt_d;
            ph_q         <= ph_d;
            settle_cnt_q <= settle_cnt_d;
            pdm_clk_q    <= pdm_clk_d;
            filt_rst_q   <= filt_rst_d;
            we_l_q       <= we_l_d;
            we_r_q       <= we_r_d;
            bit_l_q      <= bit_l_d;
            bit_r_q      <= bit_r_d;
            sample_l_q   <= sample_l_d;
            sample_r_q   <= sample_r_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
        end
    end

    assign state        = state_q;
    assign pdm_clk      = pdm_clk_q;
    assign filt_rst     = filt_rst_q;
    assign we_l         = we_l_q;
    assign we_r         = we_r_q;
    assign bit_l        = bit_l_q;
    assign bit_r        = bit_r_q;
    assign sample_l     = sample_l_q;
    assign sample_r     = sample_r_q;
    assign sample_valid = valid_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_pdm_rss_sequencer.sv
// Scoreboard bench for pdm_rss_sequencer: stimulus pushes expected sample
// pairs, a negedge monitor pops and compares them on every transfer.
module tb_pdm_rss_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        pdm_data;
    logic        pdm_clk;
    logic        filt_rst;
    logic        we_l;
    logic        we_r;
    logic        bit_l;
    logic        bit_r;
    logic [15:0] filt_out_l;
    logic [15:0] filt_out_r;
    logic [15:0] sample_l;
    logic [15:0] sample_r;
    logic        sample_valid;
    logic        sample_ready;
    logic        overrun;
    logic        clr_overrun;
    logic [1:0]  state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic [31:0] exp_q[$];
    logic        gap_chk  = 1'b0;
    logic        have_last = 1'b0;
    int          last_xfer = 0;

    pdm_rss_sequencer #(.N(16), .CLK_DIV(4), .R(10), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .en(en), .pdm_data(pdm_data),
        .pdm_clk(pdm_clk), .filt_rst(filt_rst), .we_l(we_l), .we_r(we_r),
        .bit_l(bit_l), .bit_r(bit_r), .filt_out_l(filt_out_l),
        .filt_out_r(filt_out_r), .sample_l(sample_l), .sample_r(sample_r),
        .sample_valid(sample_valid), .sample_ready(sample_ready),
        .overrun(overrun), .clr_overrun(clr_overrun), .state(state)
    );

    always #5 clk = ~clk;

    // Microphone pair model: left drives 1 while pdm_clk is high, right drives 0
    assign pdm_data = pdm_clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: bit streams on every strobe, scoreboard pop on every transfer
    always @(negedge clk) begin
        if (rst) begin
            if (we_l) check("bit_l", {31'd0, bit_l}, 32'd1);
            if (we_r) check("bit_r", {31'd0, bit_r}, 32'd0);
            if (sample_valid && sample_ready) begin
                if (exp_q.size() == 0) begin
                    check("xfer_expected", exp_q.size(), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    check("sample_l", {16'd0, sample_l}, {16'd0, e[31:16]});
                    check("sample_r", {16'd0, sample_r}, {16'd0, e[15:0]});
                end
                if (gap_chk) begin
                    if (have_last) check("xfer_gap", cyc - last_xfer, 32'd40);
                    have_last = 1'b1;
                    last_xfer = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Start-up timing from the posedge after en/rst becomes active
    task automatic start_seq();
        int n_fr = 0;
        int n_wl = 0;
        int n_wr = 0;
        int n_v  = 0;
        for (int n = 1; n <= 400; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) check("settle_state", {30'd0, state}, 32'd2);
            if (n_fr == 0 && !filt_rst) n_fr = n;
            if (n_wl == 0 && we_l) n_wl = n;
            if (n_wr == 0 && we_r) n_wr = n;
            if (sample_valid) begin
                n_v = n;
                break;
            end
        end
        check("frst_exit", n_fr, 32'd3);
        check("first_we_l", n_wl, 32'd5);
        check("first_we_r", n_wr, 32'd7);
        check("first_valid", n_v, 32'd205);
        check("run_state", {30'd0, state}, 32'd3);
    endtask

    task automatic drain();
        logic done = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        check("drain_done", {31'd0, done}, 32'd1);
        sample_ready = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sample_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check(name, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        logic seen;
        logic prev_pclk;
        int   bad;
        int   vcnt;
        rst = 1'b0; en = 1'b0; sample_ready = 1'b0; clr_overrun = 1'b0;
        filt_out_l = 16'h1234; filt_out_r = 16'hABCD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_pdm_clk", {31'd0, pdm_clk}, 32'd0);
        check("rst_filt_rst", {31'd0, filt_rst}, 32'd1);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_sample", {sample_l, sample_r}, 32'd0);
        tick();
        rst = 1'b1;

        // Normal start with ready=1: three pairs every 40 clk
        tick();
        exp_q.push_back(32'h1234ABCD);
        exp_q.push_back(32'h1234ABCD);
        exp_q.push_back(32'h1234ABCD);
        sample_ready = 1'b1;
        gap_chk = 1'b1;
        en = 1'b1;
        start_seq();
        drain();
        gap_chk = 1'b0;
        check("ovr_clean", {31'd0, overrun}, 32'd0);

        // Overrun: two captures with ready=0
        filt_out_l = 16'h1111; filt_out_r = 16'h2222;
        wait_valid("valid_pair1");
        check("pair1", {sample_l, sample_r}, 32'h11112222);
        check("ovr_after_first", {31'd0, overrun}, 32'd0);
        tick();
        filt_out_l = 16'h3333; filt_out_r = 16'h4444;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (sample_l == 16'h3333) begin
                seen = 1'b1;
                break;
            end
        end
        check("overwrite_seen", {31'd0, seen}, 32'd1);
        check("ovr_set", {31'd0, overrun}, 32'd1);
        check("valid_held", {31'd0, sample_valid}, 32'd1);
        exp_q.push_back(32'h33334444);
        tick();
        sample_ready = 1'b1;
        drain();
        tick();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        @(negedge clk);
        check("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Stop mid-period with a pending pair
        wait_valid("valid_before_stop");
        tick();
        tick();
        en = 1'b0;
        seen = 1'b0;
        prev_pclk = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (state == 2'd0) begin
                seen = 1'b1;
                break;
            end
            prev_pclk = pdm_clk;
        end
        check("stop_idle", {31'd0, seen}, 32'd1);
        check("stop_prev_low", {31'd0, prev_pclk}, 32'd0);
        check("stop_final_we_r", {31'd0, we_r}, 32'd1);
        check("stop_filt_rst", {31'd0, filt_rst}, 32'd1);
        check("stop_held_pair", {sample_l, sample_r}, 32'h33334444);
        bad = 0;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (pdm_clk || we_l || we_r || !filt_rst) bad++;
            if (sample_valid) vcnt++;
        end
        check("idle_quiet", bad, 32'd0);
        check("idle_valid_held", vcnt, 32'd20);
        check("idle_ovr", {31'd0, overrun}, 32'd0);

        // Restart with the held pair still pending
        tick();
        exp_q.push_back(32'h33334444);
        exp_q.push_back(32'h55556666);
        filt_out_l = 16'h5555; filt_out_r = 16'h6666;
        sample_ready = 1'b1;
        en = 1'b1;
        start_seq();
        drain();

        // Asynchronous reset mid-RUN with a valid pair
        wait_valid("valid_before_rst");
        tick();
        rst = 1'b0;
        #1;
        check("arst_valid", {31'd0, sample_valid}, 32'd0);
        check("arst_pdm_clk", {31'd0, pdm_clk}, 32'd0);
        check("arst_state", {30'd0, state}, 32'd0);
        check("arst_filt_rst", {31'd0, filt_rst}, 32'd1);
        tick();
        exp_q.push_back(32'h55556666);
        sample_ready = 1'b1;
        tick();
        rst = 1'b1;
        start_seq();
        drain();
        check("final_ovr", {31'd0, overrun}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
